// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the decoder-driven
// round-robin arbiter.
package decoder_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [1:0] ENA_ON  = 2'b10;
  localparam logic [1:0] ENA_OFF = 2'b01;

  // First set bit at or above ptr, wrapping 7->0.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [SEL_W-1:0] ptr
  );
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;
    dbl = {req, req};
    rot = dbl[ptr +: N_REQ];
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
    return ptr + off;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters
// and the arbiter.
interface decoder_rr_arbiter_if;
  import decoder_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [SEL_W-1:0] sel;
  logic [1:0]       ena;
  logic [N_REQ-1:0] gnt;
  logic             busy;

  modport master (
    output req,
    input  sel,
    input  ena,
    input  gnt,
    input  busy
  );

  modport slave (
    input  req,
    output sel,
    output ena,
    output gnt,
    output busy
  );

endinterface

// File: rtl/decoder_rr_arbiter_decoder.sv
// 3-to-8 decoder with a two-rail enable;
// outputs are all zero unless enabled.
module decoder
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [SEL_W-1:0] iSel,
  input  logic [1:0]       iEna,
  output logic [N_REQ-1:0] oDec
);

  always_comb begin
    oDec = '0;
    if (iEna == ENA_ON) oDec[iSel] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter with bounded hold; the
// one-hot grant comes from the decoder.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [N_REQ-1:0] iReq,
  output logic [SEL_W-1:0] oSel,
  output logic [1:0]       oEna,
  output logic [N_REQ-1:0] oGnt,
  output logic             oBusy
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [3:0]       hold_q, hold_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       ena_q, ena_d;
  logic             busy_q, busy_d;
  logic             release_w;

  assign release_w = !iReq[sel_q]
                  || (hold_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    ena_d   = ena_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (iReq != '0) begin
          state_d = GRANT;
          sel_d   = rr_pick(iReq, ptr_q);
          hold_d  = 4'd1;
          ena_d   = ENA_ON;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        // Releasing forces one dead IDLE cycle and
        // pushes the current owner to lowest priority.
        if (release_w) begin
          state_d = IDLE;
          ptr_d   = sel_q + 3'd1;
          hold_d  = 4'd0;
          ena_d   = ENA_OFF;
          busy_d  = 1'b0;
        end else begin
          hold_d  = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      sel_q   <= '0;
      ena_q   <= ENA_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
    end
  end

  assign oSel  = sel_q;
  assign oEna  = ena_q;
  assign oBusy = busy_q;

  decoder u_dec (
    .iSel (sel_q),
    .iEna (ena_q),
    .oDec (oGnt)
  );

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, meaning the maximum number of consecutive cycles one grant is held (legal range 1..8).
REQ-002 SHALL have the following ports, one per line, as name, direction, width, meaning:
- iClk  input  1  system clock; all state updates on the rising edge.
- iRst_n  input  1  reset; synchronous, active-low.
- iReq  input  8  request vector; bit k set means requester k wants the shared resource.
- oSel  output  3  index of the granted requester; feeds decoder data input.
- oEna  output  2  decoder enable pair; 2'b10 means enabled, 2'b01 means disabled.
- oGnt  output  8  one-hot grant, the decoder output; all zero when no grant.
- oBusy  output  1  high while a grant is active.

Function
REQ-003 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-004 In IDLE, if iReq is nonzero, the FSM SHALL select the first set bit at or after pointer PTR, scanning upward with wrap 7->0.
- It SHALL register that index into oSel and enter GRANT on the next edge.
REQ-005 Grant latency SHALL be exactly 1 cycle: iReq sampled at edge N gives oBusy=1 and a valid oSel/oGnt after edge N.
REQ-006 In IDLE with iReq==0, the FSM SHALL stay in IDLE with all outputs at their idle values.
REQ-007 In GRANT, the hold counter SHALL start at 1 on entry and increment by 1 per cycle that the grant remains.
REQ-008 GRANT SHALL be released at the next edge when either condition holds:
- iReq[oSel]==0, or
- the hold counter equals MAX_HOLD.
REQ-009 On release, the FSM SHALL go to IDLE for exactly one cycle (dead cycle, oEna=2'b01) and set PTR=(oSel+1) mod 8.
REQ-010 Changes to iReq bits other than oSel during GRANT SHALL NOT affect the current grant.
REQ-011 A requester that is still requesting after a MAX_HOLD release SHALL be the lowest-priority candidate in the next arbitration.
REQ-012 Output states SHALL be as follows:
- In GRANT: oEna=2'b10, oBusy=1, oGnt=8'b1<<oSel.
- In IDLE: oEna=2'b01, oBusy=0, oGnt=8'h00; oSel holds its last value.
REQ-013 Worst-case wait for a continuously requesting bit SHALL be at most 7*(MAX_HOLD+1)+1 cycles.
REQ-014 All outputs except oGnt SHALL be registered. oGnt SHALL be combinational from oSel/oEna only, through the decoder.

Reset
REQ-015 When iRst_n==0 at a rising edge, the block SHALL set state=IDLE, PTR=0, hold counter=0, oSel=3'd0, oEna=2'b01, oBusy=0, giving oGnt=8'h00.
REQ-016 Reset asserted during GRANT SHALL drop the grant at that same edge, with no dead-cycle or pointer side effects.
REQ-017 The first arbitration after reset release SHALL start scanning from requester 0.

Structure
REQ-018 A shared package SHALL hold:
- the state encoding constants IDLE=1'b0 and GRANT=1'b1;
- the enable constants ENA_ON=2'b10 and ENA_OFF=2'b01;
- the requester count 8.
REQ-019 The block SHALL instantiate exactly one sub-module, the team's existing 3-to-8 decoder "decoder".
- Its inputs are (oSel, oEna); its output is oGnt.
- The decoder SHALL NOT be reimplemented inline.
REQ-020 The priority scan SHALL be a single combinational function/block of the 8-bit request rotated by PTR. Target size is 120-250 lines.

Verification
REQ-021 Reset/idle: hold iRst_n=0 for 2 cycles, then iReq=0 for 5 cycles -> oGnt=8'h00, oEna=2'b01, oBusy=0 throughout.
REQ-022 Single request: iReq=8'h20 at edge N, held high 2 cycles, then 0 -> the following SHALL hold:
- after edge N: oSel=5, oGnt=8'h20, oEna=2'b10;
- grant lasts 2 cycles, then 1 dead cycle;
- PTR becomes 6.
REQ-023 Max hold with MAX_HOLD=4: iReq=8'h01 held constantly -> 4 cycles with oGnt=8'h01, 1 dead cycle, then the grant to 0 repeats (5-cycle period).
REQ-024 Round robin: iReq=8'h81 constant from reset -> grant order SHALL be 0, 7, 0, 7. Each grant lasts 4 cycles, separated by single dead cycles.
REQ-025 Wrap/priority: PTR=6 (after granting 5), iReq=8'h43 -> grant 6, then 0, then 1, never skipping back to 5.
REQ-026 Mid-grant reset: iRst_n=0 for one edge while oGnt=8'h08 -> after that edge oGnt=8'h00 and oBusy=0. With iReq=8'h0C, the next grant after release SHALL be to 2, since PTR=0.
